// File: rtl/image_stream_pkg.sv
// Shared types and helpers for the image pixel streamer.
// Optional feature macro: FRAME_CRC_EN (per-frame CRC-16-CCITT output).
package image_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Byte offset of the last pixel in an image
  function automatic int unsigned last_pix_off(input int unsigned img_bytes,
                                               input int unsigned bpp);
    return img_bytes - bpp;
  endfunction

  // One byte of CRC-16-CCITT, MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/image_byte_ram.sv
// NUM_IMAGES x IMG_BYTES byte store: one write port, one 1-cycle read port.
// A read of the address being written returns the previous contents.
module image_byte_ram #(
  parameter int unsigned NUM_IMAGES = 4,
  parameter int unsigned IMG_BYTES  = 30000,
  parameter int unsigned ADDR_W     = $clog2(IMG_BYTES),
  parameter int unsigned SEL_W      = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_img,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [SEL_W-1:0]  rd_img,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [NUM_IMAGES][IMG_BYTES];

  // Write port; out-of-range targets are dropped
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_img) < NUM_IMAGES) && (32'(wr_addr) < IMG_BYTES))
      mem[wr_img][wr_addr] <= wr_data;
  end

  // Registered read port (old data on same-address collision)
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_img][rd_addr];
  end

endmodule

// File: rtl/image_pixel_streamer.sv
// Streams stored byte images as little-endian packed pixels over valid/ready.
// Optional feature macro: FRAME_CRC_EN adds frame_crc/crc_valid outputs.
module image_pixel_streamer
  import image_stream_pkg::*;
#(
  parameter int unsigned NUM_IMAGES      = 4,
  parameter int unsigned IMG_BYTES       = 30000,
  parameter int unsigned BYTES_PER_PIXEL = 3,
  parameter int unsigned OUT_W           = 32,
  parameter int unsigned ADDR_W          = $clog2(IMG_BYTES),
  parameter int unsigned SEL_W           = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [SEL_W-1:0]  ld_img,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [SEL_W-1:0]  image_sel,
  output logic [OUT_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              busy,
`ifdef FRAME_CRC_EN
  output logic [15:0]       frame_crc,
  output logic              crc_valid,
`endif
  output logic              sel_err
);

  localparam int unsigned CW   = $clog2(BYTES_PER_PIXEL + 1);
  localparam int unsigned LAST = last_pix_off(IMG_BYTES, BYTES_PER_PIXEL);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  ptr, ptr_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [SEL_W-1:0]   img, img_n;
  logic               cont, cont_n;
  logic               stop_pend, stop_pend_n;
  logic               busy_n, err_n, valid_n, sof_n, eof_n;
  logic [OUT_W-1:0]   data_n;
  logic [ADDR_W-1:0]  rd_addr;
  logic [7:0]         rd_data;
  logic               sel_ok;

`ifdef FRAME_CRC_EN
  logic [15:0] crc, crc_n, crc_pix, frame_crc_n;
  logic        crc_valid_n;

  // CRC after folding in every byte of the pixel currently presented
  always_comb begin
    crc_pix = crc;
    for (int i = 0; i < BYTES_PER_PIXEL; i++) crc_pix = crc16_byte(crc_pix, pix_data[8*i +: 8]);
  end
`endif

  assign sel_ok  = (32'(image_sel) < NUM_IMAGES);
  assign rd_addr = (32'(cnt) < BYTES_PER_PIXEL) ? (ptr + ADDR_W'(cnt)) : ptr;

  image_byte_ram #(
    .NUM_IMAGES (NUM_IMAGES),
    .IMG_BYTES  (IMG_BYTES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_img  (ld_img),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_img  (img),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    img_n       = img;
    cont_n      = cont;
    stop_pend_n = stop_pend;
    busy_n      = busy;
    err_n       = sel_err;
    data_n      = pix_data;
    valid_n     = pix_valid;
    sof_n       = pix_sof;
    eof_n       = pix_eof;
`ifdef FRAME_CRC_EN
    crc_n       = crc;
    frame_crc_n = frame_crc;
    crc_valid_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            state_n     = FETCH;
            img_n       = image_sel;
            cont_n      = continuous;
            ptr_n       = '0;
            cnt_n       = '0;
            busy_n      = 1'b1;
            stop_pend_n = stop;
`ifdef FRAME_CRC_EN
            crc_n       = CRC_INIT;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
      end
      FETCH: begin
        if (stop) stop_pend_n = 1'b1;
        cnt_n = cnt + CW'(1);
        if (cnt != '0) data_n[8*(32'(cnt) - 1) +: 8] = rd_data;
        if (32'(cnt) == BYTES_PER_PIXEL) begin
          state_n = PRESENT;
          cnt_n   = '0;
          valid_n = 1'b1;
          sof_n   = (ptr == '0);
          eof_n   = (ptr == ADDR_W'(LAST));
        end
      end
      PRESENT: begin
        if (stop) stop_pend_n = 1'b1;
        if (pix_ready) begin
          valid_n = 1'b0;
          sof_n   = 1'b0;
          eof_n   = 1'b0;
          cnt_n   = '0;
          state_n = FETCH;
`ifdef FRAME_CRC_EN
          crc_n = crc_pix;
          if (pix_eof) begin
            frame_crc_n = crc_pix;
            crc_valid_n = 1'b1;
            crc_n       = CRC_INIT;
          end
`endif
          if (stop_pend || stop || (pix_eof && !cont) || (pix_eof && !sel_ok)) begin
            if (pix_eof && cont && !sel_ok && !(stop_pend || stop)) err_n = 1'b1;
            state_n     = IDLE;
            busy_n      = 1'b0;
            stop_pend_n = 1'b0;
`ifdef FRAME_CRC_EN
            crc_n       = CRC_INIT;
`endif
          end else if (pix_eof) begin
            ptr_n = '0;
            img_n = image_sel;
          end else begin
            ptr_n = ptr + ADDR_W'(BYTES_PER_PIXEL);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      img       <= '0;
      cont      <= 1'b0;
      stop_pend <= 1'b0;
      busy      <= 1'b0;
      sel_err   <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eof   <= 1'b0;
`ifdef FRAME_CRC_EN
      crc       <= CRC_INIT;
      frame_crc <= '0;
      crc_valid <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      img       <= img_n;
      cont      <= cont_n;
      stop_pend <= stop_pend_n;
      busy      <= busy_n;
      sel_err   <= err_n;
      pix_data  <= data_n;
      pix_valid <= valid_n;
      pix_sof   <= sof_n;
      pix_eof   <= eof_n;
`ifdef FRAME_CRC_EN
      crc       <= crc_n;
      frame_crc <= frame_crc_n;
      crc_valid <= crc_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Directed + randomized bench for image_pixel_streamer (small 3-image, 6-byte config).
module tb_image_pixel_streamer;

  localparam int unsigned NI  = 3;
  localparam int unsigned IB  = 6;
  localparam int unsigned BPP = 3;
  localparam int unsigned OW  = 32;
  localparam int unsigned AW  = 3;
  localparam int unsigned SW  = 2;
  localparam int unsigned NPIX = IB / BPP;

  logic clk = 1'b0, reset = 1'b1;
  logic ld_en = 1'b0, start = 1'b0, stop = 1'b0, continuous = 1'b0, pix_ready = 1'b0;
  logic [SW-1:0] ld_img = '0, image_sel = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic [OW-1:0] pix_data;
  logic pix_valid, pix_sof, pix_eof, busy, sel_err;
`ifdef FRAME_CRC_EN
  logic [15:0] frame_crc, crc_m;
  logic        crc_valid, fb;
`endif

  int checks = 0, failures = 0;
  int unsigned cyc = 0, ref_cyc = 0;
  logic [7:0] model [NI][IB];

  image_pixel_streamer #(
    .NUM_IMAGES(NI), .IMG_BYTES(IB), .BYTES_PER_PIXEL(BPP), .OUT_W(OW)
  ) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_img(ld_img), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .stop(stop), .continuous(continuous),
    .image_sel(image_sel), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eof(pix_eof), .busy(busy),
`ifdef FRAME_CRC_EN
    .frame_crc(frame_crc), .crc_valid(crc_valid),
`endif
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Little-endian packing of pixel k of an image, from the byte model
  function automatic logic [31:0] exp_pix(input int img, input int k);
    logic [31:0] p;
    p = '0;
    for (int b = 0; b < BPP; b++) p = p + (32'(model[img][k*BPP + b]) << (8*b));
    return p;
  endfunction

  task automatic write_byte(input int img, input int addr, input logic [7:0] d);
    ld_en = 1'b1; ld_img = SW'(img); ld_addr = AW'(addr); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    model[img][addr] = d;
  endtask

  task automatic pulse_start(input int sel, input logic cont, input logic stp);
    image_sel = SW'(sel); continuous = cont; start = 1'b1; stop = stp;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    ref_cyc = cyc;
  endtask

  // Wait for a pixel, check it, optionally stall, then accept it
  task automatic expect_pixel(input string tag, input int img, input int k,
                              input int hold, input logic do_stop);
    int n;
    n = 0;
    while (!pix_valid && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 32'(pix_valid), 32'd1);
    chk({tag, "_lat"}, cyc - ref_cyc, BPP + 1);
    chk({tag, "_data"}, pix_data, exp_pix(img, k));
    chk({tag, "_sof"}, 32'(pix_sof), 32'(k == 0));
    chk({tag, "_eof"}, 32'(pix_eof), 32'(k == NPIX - 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_data"}, pix_data, exp_pix(img, k));
      chk({tag, "_hold_flags"}, {29'd0, pix_valid, pix_sof, pix_eof},
          {29'd0, 1'b1, 1'(k == 0), 1'(k == NPIX - 1)});
    end
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    ref_cyc = cyc;
    if (do_stop) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {30'd0, pix_valid, busy}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {pix_data[27:0], pix_valid, pix_sof, pix_eof, busy}, 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Image 0 fixed pattern, images 1 and 2 random
    for (int a = 0; a < IB; a++) write_byte(0, a, 8'(8'h10 * (a + 1)));
    for (int i = 1; i < NI; i++)
      for (int a = 0; a < IB; a++) write_byte(i, a, 8'($urandom));

    // Single-shot frame from image 0
    pulse_start(0, 1'b0, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_model_p0", exp_pix(0, 0), 32'h0030_2010);
    expect_pixel("t1p0", 0, 0, 0, 1'b0);
    expect_pixel("t1p1", 0, 1, 0, 1'b0);
    expect_idle("t1_idle", 4);

    // Continuous with image switch, then stop during fetch of the fourth pixel
    pulse_start(0, 1'b1, 1'b0);
    expect_pixel("t2p0", 0, 0, 0, 1'b0);
    image_sel = SW'(1);
    expect_pixel("t2p1", 0, 1, 0, 1'b0);
    chk("t2_busy_wrap", 32'(busy), 32'd1);
    expect_pixel("t2p2", 1, 0, 0, 1'b1);
    expect_pixel("t2p3", 1, 1, 0, 1'b0);
    expect_idle("t4_stopped", 6);

    // Stop while idle has no lasting effect
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    expect_idle("t4_idle_stop", 3);
    pulse_start(2, 1'b0, 1'b0);
    expect_pixel("t4p0", 2, 0, 0, 1'b0);
    expect_pixel("t4p1", 2, 1, 0, 1'b0);
    expect_idle("t4_end", 2);

    // Back-pressure on the first pixel
    pulse_start(2, 1'b0, 1'b0);
    expect_pixel("t3p0", 2, 0, 10, 1'b0);
    expect_pixel("t3p1", 2, 1, 0, 1'b0);
    expect_idle("t3_end", 2);

    // start and stop together: one pixel, then idle
    pulse_start(1, 1'b1, 1'b1);
    expect_pixel("tss_p0", 1, 0, 0, 1'b0);
    expect_idle("tss_end", 4);

    // Randomized frames with random stalls and reloads
    for (int f = 0; f < 6; f++) begin
      int img;
      write_byte($urandom_range(0, NI - 1), $urandom_range(0, IB - 1), 8'($urandom));
      img = $urandom_range(0, NI - 1);
      pulse_start(img, 1'b0, 1'b0);
      for (int k = 0; k < NPIX; k++)
        expect_pixel($sformatf("rnd%0d_p%0d", f, k), img, k, $urandom_range(0, 3), 1'b0);
      expect_idle($sformatf("rnd%0d_end", f), 2);
    end

    // Invalid image at the continuous wrap point
    pulse_start(0, 1'b1, 1'b0);
    expect_pixel("twrap_p0", 0, 0, 0, 1'b0);
    image_sel = SW'(3);
    expect_pixel("twrap_p1", 0, 1, 0, 1'b0);
    chk("twrap_sel_err", 32'(sel_err), 32'd1);
    expect_idle("twrap_idle", 3);

    // Invalid start: sticky error, no stream
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    chk("t5_err_clear", 32'(sel_err), 32'd0);
    pulse_start(3, 1'b0, 1'b0);
    chk("t5_sel_err", 32'(sel_err), 32'd1);
    expect_idle("t5_no_stream", 6);

    // Reset while a pixel is presented
    pulse_start(0, 1'b1, 1'b0);
    n = 0;
    while (!pix_valid && n < 20) begin @(negedge clk); n++; end
    chk("t5_valid_before_rst", 32'(pix_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_rst", {pix_data[27:0], pix_valid, pix_sof, pix_eof, busy}, 32'd0);
    chk("t5_async_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_idle("t5_after_rst", 4);

`ifdef FRAME_CRC_EN
    // CRC over "123456"
    for (int a = 0; a < IB; a++) write_byte(0, a, 8'(8'h31 + a));
    crc_m = 16'hFFFF;
    for (int a = 0; a < IB; a++)
      for (int b = 7; b >= 0; b--) begin
        fb = crc_m[15] ^ model[0][a][b];
        crc_m = {crc_m[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    pulse_start(0, 1'b0, 1'b0);
    expect_pixel("tcrc_p0", 0, 0, 0, 1'b0);
    chk("tcrc_no_pulse", 32'(crc_valid), 32'd0);
    expect_pixel("tcrc_p1", 0, 1, 0, 1'b0);
    chk("tcrc_valid", 32'(crc_valid), 32'd1);
    chk("tcrc_value", 32'(frame_crc), 32'(crc_m));
    @(negedge clk);
    chk("tcrc_pulse_end", 32'(crc_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
